// File: rtl/fetch_queue.sv
// Instruction fetch front end: a DEPTH-entry queue between the instruction memory
// port and decode. Memory reads are in order and may be outstanding; redirects flush.
module fetch_queue #(
  parameter int unsigned    N        = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] ResultW,
  input  logic         PCSrcW,
  input  logic [N-1:0] ExtImmE,
  input  logic         BranchTakenE,
  output logic         ImemReq,
  output logic [N-1:0] ImemAddr,
  input  logic         ImemGnt,
  input  logic         ImemRValid,
  input  logic [N-1:0] ImemRData,
  input  logic         StallD,
  output logic         ValidD,
  output logic [N-1:0] InstrD,
  output logic [N-1:0] PCD,
  output logic [N-1:0] PCPlus4D
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [N-1:0]  fetch_pc_q, fetch_pc_d;
  logic [N-1:0]  pc_q    [DEPTH];
  logic [N-1:0]  pc_d    [DEPTH];
  logic [N-1:0]  instr_q [DEPTH];
  logic [N-1:0]  instr_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] alloc_q, alloc_d;
  logic [AW-1:0] fill_q, fill_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] discard_q, discard_d;

  logic          redirect;
  logic [N-1:0]  target;
  logic [CW:0]   occupancy;
  logic          grant;
  logic          pop;
  logic [CW-1:0] nfilled;

  always_comb begin
    redirect  = PCSrcW | BranchTakenE;
    target    = PCSrcW ? ResultW : ExtImmE;
    occupancy = {1'b0, count_q} + {1'b0, discard_q};
    ImemReq   = !redirect && (occupancy < DEPTH_C);
    ImemAddr  = fetch_pc_q;
    grant     = ImemReq & ImemGnt;
    ValidD    = filled_q[head_q];
    pop       = ValidD & ~StallD;
    InstrD    = instr_q[head_q];
    PCD       = pc_q[head_q];
    PCPlus4D  = pc_q[head_q] + N'(4);
  end

  always_comb begin
    nfilled = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      nfilled = nfilled + CW'(filled_q[i]);
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    filled_d   = filled_q;
    head_d     = head_q;
    alloc_d    = alloc_q;
    fill_d     = fill_q;
    count_d    = count_q;
    discard_d  = discard_q;

    if (redirect) begin
      fetch_pc_d = target;
      filled_d   = '0;
      head_d     = '0;
      alloc_d    = '0;
      fill_d     = '0;
      count_d    = '0;
      // Unfilled allocated entries become stale reads. A response this cycle retires
      // either one older stale read or one of those, so it always nets -1.
      discard_d  = discard_q + (count_q - nfilled) - CW'(ImemRValid);
    end else begin
      if (grant) begin
        pc_d[alloc_q]     = fetch_pc_q;
        filled_d[alloc_q] = 1'b0;
        alloc_d           = alloc_q + 1'b1;
        fetch_pc_d        = fetch_pc_q + N'(4);
      end
      if (ImemRValid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - 1'b1;
        end else begin
          instr_d[fill_q]  = ImemRData;
          filled_d[fill_q] = 1'b1;
          fill_d           = fill_q + 1'b1;
        end
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + 1'b1;
      end
      count_d = count_q + CW'(grant) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      filled_q  <= '0;
      head_q    <= '0;
      alloc_q   <= '0;
      fill_q    <= '0;
      count_q   <= '0;
      discard_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      filled_q   <= filled_d;
      head_q     <= head_d;
      alloc_q    <= alloc_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      discard_q  <= discard_d;
    end
  end

endmodule
